// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serializer family.
// Optional build macro used by the top: PISO_BACK_TO_BACK_EN.
package piso_pkg;

  localparam int PISO_DATA_WIDTH = 32;

  typedef enum logic [0:0] {
    PISO_IDLE  = 1'b0,
    PISO_SHIFT = 1'b1
  } piso_state_e;

  // Counter width able to hold width-1; never narrower than one bit.
  function automatic int piso_count_width(input int width);
    if (width <= 2) begin
      piso_count_width = 1;
    end else begin
      piso_count_width = $clog2(width);
    end
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with enable and zero flag; saturates at zero.
module piso_bit_counter #(
  parameter int WIDTH = 5
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_r;

  // Load has priority over decrement; nothing moves while disabled.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      count_r <= {WIDTH{1'b0}};
    end else if (enable) begin
      if (load) begin
        count_r <= load_value;
      end else if (count_r != {WIDTH{1'b0}}) begin
        count_r <= count_r - WIDTH'(1);
      end else begin
        count_r <= count_r;
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/piso_serializer_tx.sv
// MSB-first parallel-in serial-out transmitter with valid/ready load.
// Build macro PISO_BACK_TO_BACK_EN allows reload in the last bit cycle.
module piso_serializer_tx
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = PISO_DATA_WIDTH
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic                  Load_Valid_In,
  output logic                  Load_Ready_Out,
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  output logic                  Serial_Data_Out,
  output logic                  Shift_Data_Signal_Out,
  output logic                  Busy_Out,
  output logic                  Done_Out
);

  localparam int CW = piso_count_width(DATA_WIDTH);

  piso_state_e           state_r;
  piso_state_e           state_next_s;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [CW-1:0]         bit_count_s;
  logic                  count_zero_s;
  logic                  count_en_s;
  logic                  done_r;
  logic                  ready_s;
  logic                  load_fire_s;
  logic                  in_shift_s;

  assign in_shift_s  = (state_r == PISO_SHIFT);
  assign load_fire_s = Load_Valid_In & ready_s;
  assign count_en_s  = Enable_In & (in_shift_s | load_fire_s);

  // Ready is forced low while reset is held so nothing is offered early.
  always_comb begin
    ready_s = 1'b0;
    if (Reset_In || !Enable_In) begin
      ready_s = 1'b0;
    end else begin
      case (state_r)
        PISO_IDLE:  ready_s = 1'b1;
`ifdef PISO_BACK_TO_BACK_EN
        PISO_SHIFT: ready_s = count_zero_s;
`else
        PISO_SHIFT: ready_s = 1'b0;
`endif
        default:    ready_s = 1'b0;
      endcase
    end
  end

  // State register; a low enable freezes the frame in place.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_r <= PISO_IDLE;
    end else if (Enable_In) begin
      state_r <= state_next_s;
    end else begin
      state_r <= state_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      PISO_IDLE: begin
        if (load_fire_s) begin
          state_next_s = PISO_SHIFT;
        end else begin
          state_next_s = PISO_IDLE;
        end
      end
      PISO_SHIFT: begin
        if (count_zero_s && !load_fire_s) begin
          state_next_s = PISO_IDLE;
        end else begin
          state_next_s = PISO_SHIFT;
        end
      end
      default: state_next_s = PISO_IDLE;
    endcase
  end

  // Output decode; serial line holds through a disabled stretch because shift_r does.
  always_comb begin
    Serial_Data_Out       = 1'b0;
    Shift_Data_Signal_Out = 1'b0;
    Busy_Out              = 1'b0;
    if (in_shift_s) begin
      Serial_Data_Out       = shift_r[DATA_WIDTH-1];
      Shift_Data_Signal_Out = Enable_In;
      Busy_Out              = 1'b1;
    end else begin
      Serial_Data_Out       = 1'b0;
      Shift_Data_Signal_Out = 1'b0;
      Busy_Out              = 1'b0;
    end
  end

  assign Load_Ready_Out = ready_s;
  assign Done_Out       = done_r & Enable_In;

  // Shift register: load on handshake, else shift left with zero fill.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      shift_r <= {DATA_WIDTH{1'b0}};
    end else if (Enable_In && load_fire_s) begin
      shift_r <= Parallel_Data_In;
    end else if (Enable_In && in_shift_s) begin
      shift_r <= {shift_r[DATA_WIDTH-2:0], 1'b0};
    end else begin
      shift_r <= shift_r;
    end
  end

  // Done marks the cycle after the final bit, including a back-to-back reload.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      done_r <= 1'b0;
    end else if (Enable_In) begin
      done_r <= in_shift_s & count_zero_s;
    end else begin
      done_r <= done_r;
    end
  end

  piso_bit_counter #(
    .WIDTH (CW)
  ) u_bit_counter (
    .Clk_In     (Clk_In),
    .Reset_In   (Reset_In),
    .enable     (count_en_s),
    .load       (load_fire_s),
    .load_value (CW'(DATA_WIDTH - 1)),
    .count      (bit_count_s),
    .zero       (count_zero_s)
  );

endmodule
